// File: rtl/gray_to_bcd_dec_if.sv
// gray_to_bcd_dec_if: word-in / result-out handshake bundle for gray_to_bcd_dec
//   in_valid/in_ready/in_gray       : Gray word from the producer
//   out_valid/out_ready/out_bcd     : decoded BCD word to the consumer
//   err/err_mask                    : per-digit invalid-code flags and their OR
//   master = producer/consumer side, slave = decoder side
interface gray_to_bcd_dec_if #(parameter int DIGITS = 2);
  logic in_valid;
  logic in_ready;
  logic [4*DIGITS-1:0] in_gray;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic err;
  logic [DIGITS-1:0] err_mask;
  modport master(output in_valid, in_gray, out_ready, input in_ready, out_valid, out_bcd, err, err_mask);
  modport slave(input in_valid, in_gray, out_ready, output in_ready, out_valid, out_bcd, err, err_mask);
endinterface

// File: rtl/gray_to_bcd_dec.sv
// gray_to_bcd_dec: sequential Gray-to-BCD word decoder, one digit per clock, LSD first
//   clk, rst_n (async active-low), bus (gray_to_bcd_dec_if.slave)
//   DIGITS: 4-bit digits per word (1..8)
//   GRAY_DEC_ERR_EN: when defined, digits decoding above 9 set err_mask/err
module gray_to_bcd_dec #(parameter int DIGITS = 2) (
  input logic clk,
  input logic rst_n,
  gray_to_bcd_dec_if.slave bus
);
  localparam int IW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] sh;
  logic [3:0] g, b;
  logic bad;
  // captured word shifts right each digit, so the digit being decoded is always at the bottom
  assign g = sh[3:0];
  assign b[3] = g[3];
  assign b[2] = b[3] ^ g[2];
  assign b[1] = b[2] ^ g[1];
  assign b[0] = b[1] ^ g[0];
`ifdef GRAY_DEC_ERR_EN
  assign bad = b > 4'd9;
`else
  assign bad = 1'b0;
`endif
  assign bus.err = |bus.err_mask;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_bcd <= '0;
      bus.err_mask <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state <= DECODE;
          sh <= bus.in_gray;
          idx <= '0;
          bus.out_bcd <= '0;
          bus.err_mask <= '0;
          bus.in_ready <= 1'b0;
        end
        DECODE: begin
          bus.out_bcd[4*idx +: 4] <= b;
          if (bad) bus.err_mask[idx] <= 1'b1;
          sh <= sh >> 4;
          idx <= idx + 1'b1;
          if (idx == IW'(DIGITS - 1)) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_to_bcd_dec.sv
// tb_gray_to_bcd_dec: directed vectors with a per-cycle reference model for gray_to_bcd_dec
module tb_gray_to_bcd_dec;
  localparam int DIGITS = 2;
`ifdef GRAY_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  gray_to_bcd_dec_if #(.DIGITS(DIGITS)) bus();
  gray_to_bcd_dec #(.DIGITS(DIGITS)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int cmp_cnt = 0;
  int fail_cnt = 0;
  bit chk_en = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] gdec(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction
  // model: 0 = waiting for a word, 1 = decoding digit m_cnt, 2 = holding result
  int m_phase = 0;
  int m_cnt = 0;
  logic [4*DIGITS-1:0] m_word = '0;
  logic [4*DIGITS-1:0] m_bcd = '0;
  logic [DIGITS-1:0] m_mask = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt <= 0;
      m_bcd <= '0;
      m_mask <= '0;
    end else if (m_phase == 0) begin
      if (bus.in_valid) begin
        m_word <= bus.in_gray;
        m_phase <= 1;
        m_cnt <= 0;
        m_bcd <= '0;
        m_mask <= '0;
      end
    end else if (m_phase == 1) begin
      m_bcd[4*m_cnt +: 4] <= gdec(m_word[4*m_cnt +: 4]);
      if (ERR_EN && gdec(m_word[4*m_cnt +: 4]) > 4'd9) m_mask[m_cnt] <= 1'b1;
      m_cnt <= m_cnt + 1;
      if (m_cnt == DIGITS - 1) m_phase <= 2;
    end else if (bus.out_ready) begin
      m_phase <= 0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      chk("out_bcd", 32'(bus.out_bcd), 32'(m_bcd));
      chk("err_mask", 32'(bus.err_mask), 32'(m_mask));
      chk("err", 32'(bus.err), 32'(|m_mask));
    end
  end
  task automatic run_word(input logic [7:0] w, input int hold, input logic [7:0] exp_bcd, input logic [1:0] exp_mask);
    int n;
    bus.in_valid = 1'b1;
    bus.in_gray = w;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_gray = 8'hFF;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(DIGITS));
    repeat (hold) @(posedge clk);
    #1;
    chk("lit_bcd", 32'(bus.out_bcd), 32'(exp_bcd));
    chk("lit_mask", 32'(bus.err_mask), 32'(exp_mask));
    chk("lit_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("ready_back", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_gray = '0;
    bus.out_ready = 1'b0;
    chk("model_d", 32'(gdec(4'hD)), 32'h9);
    chk("model_7", 32'(gdec(4'h7)), 32'h5);
    chk("model_f", 32'(gdec(4'hF)), 32'hA);
    chk("model_c", 32'(gdec(4'hC)), 32'h8);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bcd", 32'(bus.out_bcd), 32'h00);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    run_word(8'h7D, 0, 8'h59, 2'b00);
    run_word(8'h1F, 0, 8'h1A, ERR_EN ? 2'b01 : 2'b00);
    run_word(8'h00, 3, 8'h00, 2'b00);
    bus.in_valid = 1'b1;
    bus.in_gray = 8'h7D;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_bcd", 32'(bus.out_bcd), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_word(8'h0C, 0, 8'h08, 2'b00);
    run_word(8'h1C, 1, 8'h18, 2'b00);
    run_word(8'h7D, 0, 8'h59, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
